present_sbox_layer: RTL and testbench

- Sequential, parametrised PRESENT S-box layer. Applies the 4-bit PRESENT S-box, or its inverse, to every nibble of a WIDTH-bit state.
- Uses LANES S-box instances per cycle, trading area against latency.
- Sits between round-key addition and the permutation layer in PRESENT encrypt/decrypt datapaths.
- Uses a valid/ready handshake on both sides, so it can stall against downstream backpressure.

---
 rtl/present_pkg.sv | 14 +
 rtl/present_sbox4.sv | 12 +
 rtl/present_sbox_layer.sv | 79 +++++++
 tb/tb_present_sbox_layer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: PRESENT nibble substitution tables, FSM encoding and round-count helper.
package present_pkg;

    // Entry n of each table sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX_FWD = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int rounds(input int width, input int lanes);
        return width / 4 / lanes;
    endfunction

endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: combinational 4-bit PRESENT S-box with forward/inverse select.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       inv,
    output logic [3:0] sub
);

    assign sub = inv ? SBOX_INV[{nib, 2'b00} +: 4] : SBOX_FWD[{nib, 2'b00} +: 4];

endmodule

// File: rtl/present_sbox_layer.sv
// present_sbox_layer: sequential PRESENT S-box layer, LANES nibbles per cycle,
// rotating the state so the original nibble order returns after ROUNDS cycles.
module present_sbox_layer
    import present_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int ROUNDS = rounds(WIDTH, LANES);
    localparam int CW     = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
    localparam int SW     = 4 * LANES;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [SW-1:0]    sub;
    logic             inv_q;
    logic [CW-1:0]    cnt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        present_sbox4 u_sbox (.nib(sreg[4*i +: 4]), .inv(inv_q), .sub(sub[4*i +: 4]));
    end

    // Substituted low nibbles re-enter at the top; a full-width shift is zero when ROUNDS==1.
    assign sreg_nxt = (sreg >> SW) | (WIDTH'(sub) << (WIDTH - SW));
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            inv_q     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    sreg <= sreg_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ROUNDS - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= sreg_nxt;
                    end
                end
                IDLE, DONE: begin
                    if (in_valid && in_ready) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                        sreg      <= in_data;
                        inv_q     <= in_inv;
                        cnt       <= '0;
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_sbox_layer.sv
// tb_present_sbox_layer: directed and random checks of the S-box layer against a table-driven model.
module tb_present_sbox_layer;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_inv, out_ready, in_ready, out_valid, busy;
    logic [63:0] in_data, out_data;
    logic        sv, si;
    logic [63:0] sd;
    logic [2:0]  ov_s, ir_s, bz_s;
    logic [63:0] od_s [3];
    int          pass_cnt = 0;
    int          total = 0;

    logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    always #5 clk = ~clk;

    present_sbox_layer #(.WIDTH(64), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));
    present_sbox_layer #(.WIDTH(64), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir_s[0]), .in_data(sd), .in_inv(si),
        .out_valid(ov_s[0]), .out_ready(1'b1), .out_data(od_s[0]), .busy(bz_s[0]));
    present_sbox_layer #(.WIDTH(64), .LANES(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir_s[1]), .in_data(sd), .in_inv(si),
        .out_valid(ov_s[1]), .out_ready(1'b1), .out_data(od_s[1]), .busy(bz_s[1]));
    present_sbox_layer #(.WIDTH(64), .LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir_s[2]), .in_data(sd), .in_inv(si),
        .out_valid(ov_s[2]), .out_ready(1'b1), .out_data(od_s[2]), .busy(bz_s[2]));

    function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv ? inv_t[d[4*n +: 4]] : fwd_t[d[4*n +: 4]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(output int c);
        c = 0;
        while (!out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] d, input logic inv, input logic [63:0] exp);
        int c;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 40) begin
            @(negedge clk);
            c++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        @(negedge clk);
        in_valid = 1'b0;
        in_inv   = ~inv;
        wait_out(c);
        check({tag, "_lat"}, 64'(c), 64'd4);
        check({tag, "_data"}, out_data, exp);
    endtask

    initial begin
        int c;
        logic seen;
        logic [63:0] d;
        int lat [3];
        logic [63:0] dat [3];
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        sv = 1'b0; sd = '0; si = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_data", out_data, 64'd0);
        run_block("fwd", 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712);
        run_block("zero", 64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC);
        run_block("inv", 64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF);
        // backpressure then back-to-back acceptance
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; in_inv = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(c);
        check("bp_lat", 64'(c), 64'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, 64'hC56B90AD3EF84712);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b1; in_data = 64'hFFFFFFFFFFFFFFFF; out_ready = 1'b1;
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_no_valid", 64'(out_valid), 64'd0);
        wait_out(c);
        check("b2b_lat", 64'(c), 64'd4);
        check("b2b_data", out_data, 64'h2222222222222222);
        // reset during the second busy cycle
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; in_inv = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_data", out_data, 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("mrst_no_pulse", 64'(seen), 64'd0);
        run_block("post_rst", 64'hFEDCBA9876543210, 1'b0, model(64'hFEDCBA9876543210, 1'b0));
        for (int k = 0; k < 16; k++) begin
            d = {$urandom, $urandom};
            run_block(k[0] ? "rnd_inv" : "rnd_fwd", d, k[0], model(d, k[0]));
        end
        // LANES sweep: 1, 2, 16 lanes run side by side
        for (int r = 0; r < 4; r++) begin
            d = (r == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
            @(negedge clk);
            sv = 1'b1; sd = d; si = (r > 1);
            @(negedge clk);
            sv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                lat[k] = 99;
                dat[k] = 'x;
            end
            for (int cc = 0; cc < 20; cc++) begin
                for (int k = 0; k < 3; k++)
                    if (ov_s[k] && lat[k] == 99) begin
                        lat[k] = cc;
                        dat[k] = od_s[k];
                    end
                @(negedge clk);
            end
            check("sw_l1_lat", 64'(lat[0]), 64'd16);
            check("sw_l2_lat", 64'(lat[1]), 64'd8);
            check("sw_l16_lat", 64'(lat[2]), 64'd1);
            for (int k = 0; k < 3; k++) check("sw_data", dat[k], model(d, r > 1));
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
